pulse_period_meter: RTL and testbench
=====================================

// Module: pulse_period_meter
// PURPOSE
//   Measures the sys_clk-cycle distance between consecutive rising edges of a
//   pulse train (e.g. the 1 s / N ms strobe from the pulse generator, or an
//   external pin). Reports the last period, min/max since clear, a measurement
//   count, and a sticky timeout when no edge arrives within TIMEOUT cycles.
//   Sits next to the generator as its self-check / on-board frequency meter.
// PARAMETERS
//   CNT_W    40                  width of cycle counter and period outputs
//   TIMEOUT  40'd60_000_000_000  max cycles waited for the next edge (> 1 s at 50 MHz)
// PORTS
//   sys_clk       in   1      system clock, all logic on posedge
//   rst           in   1      synchronous, active-high reset
//   pulse_in      in   1      asynchronous pulse input
//   clear         in   1      sync clear of stats/timeout; same effect as rst except sync flops
//   period        out  CNT_W  last measured period, in cycles
//   period_valid  out  1      1-cycle strobe: period/min/max/meas_cnt updated
//   min_period    out  CNT_W  smallest period since rst/clear
//   max_period    out  CNT_W  largest period since rst/clear
//   meas_cnt      out  16     measurements since rst/clear, saturates at 16'hFFFF
//   timeout       out  1      sticky: TIMEOUT cycles passed in MEASURE with no edge
// BEHAVIOUR
//   - Reset values: period=0, period_valid=0, min_period=all ones,
//     max_period=0, meas_cnt=0, timeout=0, sync flops=0, state=IDLE, cnt=0.
//   - pulse_in passes through a 2-flop synchronizer, then a prev-flop edge
//     detector: rise = sync & ~prev. Rise is asserted 3 cycles after the first
//     sample of pulse_in=1. Rise needs a low sample between edges, so min
//     measurable period is 2.
//   - FSM, 2 states:
//     IDLE:    cnt held at 0. On rise: cnt<=1, go MEASURE. No valid strobe.
//     MEASURE: cnt<=cnt+1 each cycle. On rise: period<=cnt, cnt<=1,
//              min_period<=min(min_period,cnt), max_period<=max(max_period,cnt),
//              meas_cnt<=meas_cnt+1 (saturating). period_valid=1 in the cycle
//              after the rise (registered); stay in MEASURE.
//              With no rise and cnt==TIMEOUT: timeout<=1, go IDLE; no strobe,
//              period/min/max/meas_cnt unchanged.
//   - Rises exactly P cycles apart yield period==P.
//   - cnt never exceeds TIMEOUT, so it cannot wrap; TIMEOUT < 2^CNT_W is required.
//   - Rise in the same cycle as cnt==TIMEOUT: rise wins, period=TIMEOUT,
//     timeout not set.
//   - timeout stays set until rst/clear; measuring resumes on the next rise
//     regardless of timeout.
//   - clear (or rst) in the same cycle as a rise: clear wins, rise discarded,
//     state=IDLE; the next rise starts a fresh measurement.
//   - rst/clear mid-measurement: partial count discarded, period_valid=0 the
//     next cycle.
//   - period_valid never high on two consecutive cycles (min period 2).
// TESTING
//   1. rst, rises every 1000 cycles x4 -> 3 strobes, period=1000, min=max=1000,
//      meas_cnt=3, timeout=0.
//   2. Rise spacings 500, 2000, 800 -> period=800, min=500, max=2000, meas_cnt=3.
//   3. TIMEOUT=100 override, one rise then silence -> timeout=1 after 100
//      cycles, no strobe, state IDLE; the next two rises 40 apart give period=40.
//   4. TIMEOUT=100, second rise aligned with cnt==100 -> period=100, timeout=0.
//   5. clear asserted with a rise, after 5 measurements -> min=all ones,
//      max=0, meas_cnt=0, timeout=0, no strobe; two later rises restart counting.
//   6. Toggle pulse_in 0/1 every cycle (period 2), meas_cnt preloaded near
//      16'hFFFF -> period=2, strobes every other cycle, meas_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures sys_clk cycles between consecutive rising edges of an asynchronous pulse train.
// Reports the last period, min/max since clear, a saturating count and a sticky timeout.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | waiting for the first rise; counter held at 0
//   S_MEASURE | counting cycles since the last rise; next rise closes a period

module pulse_period_meter #(
    parameter int               CNT_W   = 40,
    parameter logic [CNT_W-1:0] TIMEOUT = 40'd60_000_000_000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [15:0]      meas_cnt,
    output logic             timeout
);

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [15:0]      r_meas_cnt;
    logic             r_valid;
    logic             r_timeout;
    logic             w_rise;

    // clear leaves the synchronizer alone so an edge in flight is not re-detected
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

    always_ff @(posedge sys_clk) begin
        if (rst || clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_min      <= '1;
            r_max      <= '0;
            r_meas_cnt <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        // a rise on the terminal count still closes a valid period
                        r_period <= r_cnt;
                        r_cnt    <= CNT_ONE;
                        r_valid  <= 1'b1;
                        if (r_cnt < r_min) r_min <= r_cnt;
                        if (r_cnt > r_max) r_max <= r_cnt;
                        if (r_meas_cnt != 16'hFFFF) r_meas_cnt <= r_meas_cnt + 16'd1;
                    end else if (r_cnt == TIMEOUT) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign min_period   = r_min;
    assign max_period   = r_max;
    assign meas_cnt     = r_meas_cnt;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a default-timeout instance and a TIMEOUT=100 instance
// share the same stimulus; each scenario checks the instance it targets.

module tb_pulse_period_meter;

    localparam int CNT_W = 40;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             pulse_in = 1'b0;

    logic [CNT_W-1:0] period_a, min_a, max_a;
    logic             valid_a, timeout_a;
    logic [15:0]      meas_a;
    logic [CNT_W-1:0] period_t, min_t, max_t;
    logic             valid_t, timeout_t;
    logic [15:0]      meas_t;

    int nvec = 0;
    int nerr = 0;
    int strobes_a = 0, strobes_t = 0, consec_a = 0, consec_t = 0;
    logic prev_va = 1'b0, prev_vt = 1'b0;
    int s0;

    pulse_period_meter #(.CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
        .period(period_a), .period_valid(valid_a), .min_period(min_a),
        .max_period(max_a), .meas_cnt(meas_a), .timeout(timeout_a)
    );

    pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(40'd100)) dut_t (
        .sys_clk(sys_clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
        .period(period_t), .period_valid(valid_t), .min_period(min_t),
        .max_period(max_t), .meas_cnt(meas_t), .timeout(timeout_t)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (valid_a) strobes_a++;
        if (valid_t) strobes_t++;
        if (valid_a && prev_va) consec_a++;
        if (valid_t && prev_vt) consec_t++;
        prev_va = valid_a;
        prev_vt = valid_t;
    end

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1; clear = 1'b0; pulse_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    // one-cycle high pulse; the next call's rise lands exactly sp cycles later
    task automatic pulse_gap(input int sp);
        pulse_in = 1'b1;
        @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (sp - 1) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (period_a !== 40'd0)  begin nerr++; $display("FAIL reset_period got %0h want 0", period_a); end
        nvec++; if (valid_a !== 1'b0)    begin nerr++; $display("FAIL reset_valid got %b want 0", valid_a); end
        nvec++; if (min_a !== {CNT_W{1'b1}}) begin nerr++; $display("FAIL reset_min got %0h want ffffffffff", min_a); end
        nvec++; if (max_a !== 40'd0)     begin nerr++; $display("FAIL reset_max got %0h want 0", max_a); end
        nvec++; if (meas_a !== 16'd0)    begin nerr++; $display("FAIL reset_meas got %0h want 0", meas_a); end
        nvec++; if (timeout_a !== 1'b0)  begin nerr++; $display("FAIL reset_timeout got %b want 0", timeout_a); end
    endtask

    task automatic test_steady();
        do_reset();
        s0 = strobes_a;
        repeat (4) pulse_gap(1000);
        nvec++; if (strobes_a - s0 !== 3) begin nerr++; $display("FAIL steady_strobes got %0d want 3", strobes_a - s0); end
        nvec++; if (period_a !== 40'd1000) begin nerr++; $display("FAIL steady_period got %0d want 1000", period_a); end
        nvec++; if (min_a !== 40'd1000)    begin nerr++; $display("FAIL steady_min got %0d want 1000", min_a); end
        nvec++; if (max_a !== 40'd1000)    begin nerr++; $display("FAIL steady_max got %0d want 1000", max_a); end
        nvec++; if (meas_a !== 16'd3)      begin nerr++; $display("FAIL steady_meas got %0d want 3", meas_a); end
        nvec++; if (timeout_a !== 1'b0)    begin nerr++; $display("FAIL steady_timeout got %b want 0", timeout_a); end
    endtask

    task automatic test_minmax();
        do_reset();
        pulse_gap(500); pulse_gap(2000); pulse_gap(800); pulse_gap(10);
        nvec++; if (period_a !== 40'd800) begin nerr++; $display("FAIL mm_period got %0d want 800", period_a); end
        nvec++; if (min_a !== 40'd500)    begin nerr++; $display("FAIL mm_min got %0d want 500", min_a); end
        nvec++; if (max_a !== 40'd2000)   begin nerr++; $display("FAIL mm_max got %0d want 2000", max_a); end
        nvec++; if (meas_a !== 16'd3)     begin nerr++; $display("FAIL mm_meas got %0d want 3", meas_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        s0 = strobes_t;
        pulse_in = 1'b1;
        @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (101) @(negedge sys_clk);
        nvec++; if (timeout_t !== 1'b0) begin nerr++; $display("FAIL to_early got %b want 0", timeout_t); end
        @(negedge sys_clk);
        nvec++; if (timeout_t !== 1'b1) begin nerr++; $display("FAIL to_set got %b want 1", timeout_t); end
        nvec++; if (strobes_t - s0 !== 0) begin nerr++; $display("FAIL to_nostrobe got %0d want 0", strobes_t - s0); end
        repeat (10) @(negedge sys_clk);
        pulse_gap(40); pulse_gap(10);
        nvec++; if (period_t !== 40'd40) begin nerr++; $display("FAIL to_resume_period got %0d want 40", period_t); end
        nvec++; if (meas_t !== 16'd1)    begin nerr++; $display("FAIL to_resume_meas got %0d want 1", meas_t); end
        nvec++; if (strobes_t - s0 !== 1) begin nerr++; $display("FAIL to_resume_strobes got %0d want 1", strobes_t - s0); end
        nvec++; if (timeout_t !== 1'b1)  begin nerr++; $display("FAIL to_sticky got %b want 1", timeout_t); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        pulse_gap(100); pulse_gap(5);
        nvec++; if (period_t !== 40'd100) begin nerr++; $display("FAIL edge_period got %0d want 100", period_t); end
        nvec++; if (timeout_t !== 1'b0)   begin nerr++; $display("FAIL edge_timeout got %b want 0", timeout_t); end
        nvec++; if (meas_t !== 16'd1)     begin nerr++; $display("FAIL edge_meas got %0d want 1", meas_t); end
        do_reset();
        s0 = strobes_t;
        pulse_gap(101); pulse_gap(5);
        nvec++; if (timeout_t !== 1'b1)   begin nerr++; $display("FAIL over_timeout got %b want 1", timeout_t); end
        nvec++; if (period_t !== 40'd0)   begin nerr++; $display("FAIL over_period got %0d want 0", period_t); end
        nvec++; if (strobes_t - s0 !== 0) begin nerr++; $display("FAIL over_strobes got %0d want 0", strobes_t - s0); end
    endtask

    task automatic test_clear();
        do_reset();
        repeat (6) pulse_gap(300);
        nvec++; if (meas_a !== 16'd5) begin nerr++; $display("FAIL clr_pre_meas got %0d want 5", meas_a); end
        s0 = strobes_a;
        pulse_in = 1'b1;
        @(negedge sys_clk);
        pulse_in = 1'b0;
        @(negedge sys_clk);
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0;
        repeat (5) @(negedge sys_clk);
        nvec++; if (min_a !== {CNT_W{1'b1}}) begin nerr++; $display("FAIL clr_min got %0h want ffffffffff", min_a); end
        nvec++; if (max_a !== 40'd0)     begin nerr++; $display("FAIL clr_max got %0d want 0", max_a); end
        nvec++; if (meas_a !== 16'd0)    begin nerr++; $display("FAIL clr_meas got %0d want 0", meas_a); end
        nvec++; if (timeout_a !== 1'b0)  begin nerr++; $display("FAIL clr_timeout got %b want 0", timeout_a); end
        nvec++; if (period_a !== 40'd0)  begin nerr++; $display("FAIL clr_period got %0d want 0", period_a); end
        nvec++; if (strobes_a - s0 !== 0) begin nerr++; $display("FAIL clr_strobes got %0d want 0", strobes_a - s0); end
        pulse_gap(200); pulse_gap(5);
        nvec++; if (meas_a !== 16'd1)    begin nerr++; $display("FAIL clr_restart_meas got %0d want 1", meas_a); end
        nvec++; if (period_a !== 40'd200) begin nerr++; $display("FAIL clr_restart_period got %0d want 200", period_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        force dut.r_meas_cnt = 16'hFFFC;
        #1;
        release dut.r_meas_cnt;
        s0 = strobes_a;
        for (int i = 0; i < 20; i++) begin
            pulse_in = (i % 2 == 0);
            @(negedge sys_clk);
        end
        pulse_in = 1'b0;
        repeat (6) @(negedge sys_clk);
        nvec++; if (period_a !== 40'd2)   begin nerr++; $display("FAIL b2b_period got %0d want 2", period_a); end
        nvec++; if (min_a !== 40'd2)      begin nerr++; $display("FAIL b2b_min got %0d want 2", min_a); end
        nvec++; if (max_a !== 40'd2)      begin nerr++; $display("FAIL b2b_max got %0d want 2", max_a); end
        nvec++; if (meas_a !== 16'hFFFF)  begin nerr++; $display("FAIL b2b_meas_sat got %0h want ffff", meas_a); end
        nvec++; if (strobes_a - s0 !== 9) begin nerr++; $display("FAIL b2b_strobes got %0d want 9", strobes_a - s0); end
        nvec++; if (consec_a !== 0)       begin nerr++; $display("FAIL b2b_consecutive got %0d want 0", consec_a); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_minmax();
        test_timeout();
        test_timeout_edge();
        test_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
